// File: rtl/quad_pwm_ramp.sv
// CH-channel motor PWM driver sharing one period counter; each duty ramps toward its target once per period.
// Optional QUAD_PWM_STAGGER_EN phase-shifts channel i's compare counter by i*2^CNT_W/CH.
module quad_pwm_ramp #(
  parameter int unsigned CH        = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned CNT_STEP  = 256,
  parameter int unsigned MIN_SPEED = 256,
  parameter int unsigned MAX_SPEED = 65535,
  parameter int unsigned ACC       = 2560,
  parameter int unsigned DEAD_ZONE = 1280
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm_i,
  input  logic [CH*CNT_W-1:0]   speed_in_i,
  input  logic                  speed_valid_i,
  output logic                  speed_ready_o,
  output logic [CH-1:0]         pwm_out_o,
  output logic [CH-1:0]         busy_o,
  output logic                  period_tick_o
);

  localparam int unsigned DW = CNT_W + 2;
  localparam int unsigned XW = CNT_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  localparam logic [CNT_W-1:0]     STEP_V = CNT_W'(CNT_STEP);
  localparam logic [CNT_W-1:0]     PEND_V = CNT_W'(0) - STEP_V;
  localparam logic [CNT_W-1:0]     MIN_V  = CNT_W'(MIN_SPEED);
  localparam logic [CNT_W-1:0]     MAX_V  = CNT_W'(MAX_SPEED);
  localparam logic [XW-1:0]        MIN_X  = XW'(MIN_SPEED);
  localparam logic [XW-1:0]        MAX_X  = XW'(MAX_SPEED);
  localparam logic [XW-1:0]        ACC_X  = XW'(ACC);
  localparam logic signed [DW-1:0] DZ_P   = DW'(DEAD_ZONE);
  localparam logic signed [DW-1:0] DZ_N   = -DZ_P;

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CH-1:0][CNT_W-1:0]  duty_q, duty_d, target_q, target_d;
  logic [CH-1:0][CNT_W-1:0]  cnt_ch, spd;
  logic [CH-1:0][XW-1:0]     step_x;
  logic [CH-1:0][1:0]        state_q, state_d;
  logic [CH-1:0]             pwm_q, pwm_d, busy_q, busy_d;
  logic                      eval_q, eval_d, tick_q, tick_d;
  logic                      pend, accept;

  // Direction from the signed distance target - duty, with dead-zone snap to IDLE.
  function automatic logic [1:0] eval_state(input logic signed [DW-1:0] d);
    logic [1:0] st;
    st = ST_IDLE;
    if (d > DZ_P)      st = ST_UP;
    else if (d < DZ_N) st = ST_DOWN;
    return st;
  endfunction

  assign speed_ready_o = arm_i & ~rst;

  always_comb begin
    pend     = (cnt_q == PEND_V);
    accept   = speed_valid_i & speed_ready_o;
    cnt_d    = cnt_q + STEP_V;
    tick_d   = pend;
    eval_d   = accept;
    duty_d   = duty_q;
    target_d = target_q;
    state_d  = state_q;
    pwm_d    = '0;
    busy_d   = '0;
    step_x   = '0;
    cnt_ch   = '0;
    spd      = '0;
    for (int unsigned i = 0; i < CH; i++) begin
`ifdef QUAD_PWM_STAGGER_EN
      cnt_ch[i] = cnt_q + CNT_W'(i * ((2 ** CNT_W) / CH));
`else
      cnt_ch[i] = cnt_q;
`endif
      pwm_d[i] = arm_i & (cnt_ch[i] < duty_q[i]);

      // Candidate duty for this period's step, in CNT_W+1 bits so nothing wraps.
      case (state_q[i])
        ST_UP: begin
          step_x[i] = {1'b0, duty_q[i]} + ACC_X;
          if (step_x[i] > MAX_X) step_x[i] = MAX_X;
        end
        ST_DOWN:
          step_x[i] = ({1'b0, duty_q[i]} < MIN_X + ACC_X) ? MIN_X : ({1'b0, duty_q[i]} - ACC_X);
        default:
          step_x[i] = {1'b0, target_q[i]};
      endcase

      spd[i] = speed_in_i[i*CNT_W +: CNT_W];
      if (!arm_i) begin
        duty_d[i]   = MIN_V;
        target_d[i] = MIN_V;
        state_d[i]  = ST_IDLE;
      end else begin
        // Step uses the current target; a coinciding load is picked up by the following evaluation.
        if (pend) begin
          state_d[i] = eval_state({2'b00, target_q[i]} - {1'b0, step_x[i]});
          duty_d[i]  = (state_d[i] == ST_IDLE) ? target_q[i] : step_x[i][CNT_W-1:0];
        end else if (eval_q) begin
          state_d[i] = eval_state({2'b00, target_q[i]} - {2'b00, duty_q[i]});
        end
        if (accept) begin
          if (spd[i] < MIN_V)                target_d[i] = MIN_V;
          else if ({1'b0, spd[i]} > MAX_X)   target_d[i] = MAX_V;
          else                               target_d[i] = spd[i];
        end
      end
      busy_d[i] = (state_d[i] != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      duty_q   <= {CH{MIN_V}};
      target_q <= {CH{MIN_V}};
      state_q  <= {CH{ST_IDLE}};
      eval_q   <= 1'b0;
      tick_q   <= 1'b0;
      pwm_q    <= '0;
      busy_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      state_q  <= state_d;
      eval_q   <= eval_d;
      tick_q   <= tick_d;
      pwm_q    <= pwm_d;
      busy_q   <= busy_d;
    end
  end

  assign pwm_out_o     = pwm_q;
  assign busy_o        = busy_q;
  assign period_tick_o = tick_q;

endmodule

// File: tb/tb_quad_pwm_ramp.sv
// Scoreboard bench for quad_pwm_ramp: an independent cycle model queues expected outputs, negedge pops and compares.
module tb_quad_pwm_ramp;

  localparam int CH = 4;
`ifdef QUAD_PWM_STAGGER_EN
  localparam int STAG = 1;
`else
  localparam int STAG = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, arm, valid;
  logic [63:0] speed;
  logic        ready, tick;
  logic [3:0]  pwm, busy;

  always #5 clk = ~clk;

  quad_pwm_ramp dut (
    .clk           (clk),
    .rst           (rst),
    .arm_i         (arm),
    .speed_in_i    (speed),
    .speed_valid_i (valid),
    .speed_ready_o (ready),
    .pwm_out_o     (pwm),
    .busy_o        (busy),
    .period_tick_o (tick)
  );

  typedef struct packed {
    logic [3:0] pwm;
    logic [3:0] busy;
    logic       tick;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hi_cnt[4];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int dir_of(input int diff);
    if (diff > 1280)  return 1;
    if (diff < -1280) return -1;
    return 0;
  endfunction

  // Reference model: integer arithmetic, one update per rising edge.
  int   m_cnt, m_duty[4], m_tgt[4], m_st[4];
  bit   m_eval;
  exp_t m_e;

  always @(posedge clk) begin : model
    bit m_pend;
    int nd, ci, s;
    m_e = '0;
    if (rst) begin
      m_cnt = 0;
      m_eval = 0;
      for (int i = 0; i < CH; i++) begin
        m_duty[i] = 256; m_tgt[i] = 256; m_st[i] = 0;
      end
    end else begin
      m_pend = (m_cnt == 65280);
      m_e.tick = m_pend;
      for (int i = 0; i < CH; i++) begin
        ci = (m_cnt + STAG * i * 16384) % 65536;
        m_e.pwm[i] = arm && (ci < m_duty[i]);
      end
      if (!arm) begin
        m_eval = 0;
        for (int i = 0; i < CH; i++) begin
          m_duty[i] = 256; m_tgt[i] = 256; m_st[i] = 0;
        end
      end else begin
        for (int i = 0; i < CH; i++) begin
          if (m_pend) begin
            if (m_st[i] == 1)       nd = (m_duty[i] + 2560 > 65535) ? 65535 : m_duty[i] + 2560;
            else if (m_st[i] == -1) nd = (m_duty[i] - 2560 < 256) ? 256 : m_duty[i] - 2560;
            else                    nd = m_tgt[i];
            m_st[i]   = dir_of(m_tgt[i] - nd);
            m_duty[i] = (m_st[i] == 0) ? m_tgt[i] : nd;
          end else if (m_eval) begin
            m_st[i] = dir_of(m_tgt[i] - m_duty[i]);
          end
        end
        m_eval = valid;
        if (valid) begin
          for (int i = 0; i < CH; i++) begin
            s = int'(speed[i*16 +: 16]);
            m_tgt[i] = (s < 256) ? 256 : s;
          end
        end
      end
      m_cnt = (m_cnt + 256) % 65536;
    end
    for (int i = 0; i < CH; i++) m_e.busy[i] = (m_st[i] != 0);
    sb_q.push_back(m_e);
  end

  always @(negedge clk) begin : compare
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("pwm_out", pwm, e.pwm);
      check_eq("busy", busy, e.busy);
      check_eq("period_tick", tick, e.tick);
      check_eq("speed_ready", ready, arm & ~rst);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [63:0] s);
    speed = s;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (tick) ok = 1;
    end
    check_eq("tick_wait", ok, 1);
  endtask

  // Number of pends until busy[ch] drops; -1 if it never does within maxp.
  task automatic pends_until_idle(input int ch, input int maxp, output int np);
    np = -1;
    for (int p = 1; p <= maxp; p++) begin
      wait_tick();
      if (!busy[ch]) begin
        np = p;
        break;
      end
    end
  endtask

  task automatic measure();
    wait_tick();
    for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) hi_cnt[i] += int'(pwm[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int np;
    rst = 1'b1; arm = 1'b0; valid = 1'b0; speed = '0;
    cyc(3);
    check_eq("rst_pwm", pwm, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tick", tick, 0);
    check_eq("rst_ready", ready, 0);
    rst = 1'b0; arm = 1'b1;
    cyc(2);

    // Idle throttle: high only while cnt==0
    measure();
    for (int i = 0; i < CH; i++) check_eq("idle_hi", hi_cnt[i], 1);
    check_eq("idle_busy", busy, 0);

    // Zero targets clamp to MIN_SPEED: nothing moves
    send(64'h0);
    cyc(3);
    check_eq("clamp_busy", busy, 0);
    wait_tick();
    check_eq("clamp_busy_pend", busy, 0);

    // ch0 ramp 256 -> 30976
    wait_tick();
    send({16'd256, 16'd256, 16'd256, 16'd30976});
    cyc(1);
    check_eq("up_busy_start", busy, 4'b0001);
    pends_until_idle(0, 40, np);
    check_eq("ch0_pends", np, 12);
    check_eq("ch0_others_idle", busy, 0);
    measure();
    check_eq("ch0_hi", hi_cnt[0], 121);
    check_eq("ch1_hi_before", hi_cnt[1], 1);

    // ch1 to full scale: the 25th step lands 1279 short and snaps to 65535
    wait_tick();
    send({16'd256, 16'd256, 16'd65535, 16'd30976});
    pends_until_idle(1, 40, np);
    check_eq("ch1_pends", np, 25);
    measure();
    check_eq("ch1_hi_full", hi_cnt[1], 256);
    check_eq("ch0_hi_kept", hi_cnt[0], 121);

    // Retarget mid-ramp: 15616 UP -> target 256, next pend 13056
    arm = 1'b0; cyc(2); arm = 1'b1; cyc(1);
    wait_tick();
    send({16'd256, 16'd256, 16'd256, 16'd30976});
    repeat (6) wait_tick();
    send({16'd256, 16'd256, 16'd256, 16'd256});
    measure();
    check_eq("retarget_hi", hi_cnt[0], 51);
    check_eq("retarget_busy", busy, 4'b0001);

    // Disarm mid-ramp, then re-arm and ramp from MIN_SPEED
    arm = 1'b0;
    @(negedge clk);
    check_eq("disarm_pwm", pwm, 0);
    check_eq("disarm_busy", busy, 0);
    check_eq("disarm_ready", ready, 0);
    cyc(3);
    arm = 1'b1;
    cyc(1);
    wait_tick();
    send({16'd256, 16'd256, 16'd256, 16'd5376});
    pends_until_idle(0, 10, np);
    check_eq("rearm_pends", np, 2);
    measure();
    check_eq("rearm_hi", hi_cnt[0], 21);

    // Reset mid-ramp
    send({16'd256, 16'd256, 16'd256, 16'd30976});
    repeat (2) wait_tick();
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_pwm", pwm, 0);
    rst = 1'b0;
    cyc(2);

    // Command accepted exactly in the pend cycle
    wait_tick();
    cyc(255);
    send({16'd256, 16'd40000, 16'd256, 16'd256});
    pends_until_idle(2, 30, np);
    check_eq("pend_accept_pends", np, 16);

    // Random commands and arm toggles, checked by the scoreboard
    for (int k = 0; k < 3000; k++) begin
      valid = ($urandom_range(0, 39) == 0);
      speed = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) speed[15:0] = 16'hFFFF;
      if ($urandom_range(0, 9) == 0) speed[31:16] = 16'h0000;
      if ($urandom_range(0, 499) == 0) arm = ~arm;
      @(negedge clk);
    end
    valid = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
